// File: rtl/crc_pkg.sv
// Shared constants and FSM state encoding for the CRC frame controller.
package crc_pkg;

    localparam int          DATA_W    = 16;
    localparam logic [15:0] CRC_POLY  = 16'h1021;
    localparam logic [15:0] CRC_INIT  = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CRC  = 2'd2,
        ST_DROP = 2'd3
    } crc_state_e;

endpackage

// File: rtl/crc_frame_ctrl_if.sv
// Requester, downstream and status signals of crc_frame_ctrl; master is the controller side.
interface crc_frame_ctrl_if;
    import crc_pkg::*;

    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_last;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_last;
    logic              req1_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_is_crc;
    logic              out_ready;
    logic [1:0]        grant;
    logic              err_trunc;

    modport master (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_data, out_last, out_is_crc,
        output grant, err_trunc
    );

    modport slave (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_data, out_last, out_is_crc,
        input  grant, err_trunc
    );

endinterface

// File: rtl/crc16_next.sv
// Combinational one-word CRC-16 (poly 0x1021, MSB-first) update: 16 serial steps unrolled.
module crc16_next
    import crc_pkg::*;
(
    input  logic [15:0] state,
    input  logic [15:0] data,
    output logic [15:0] next
);

    logic [15:0] c;
    logic        fb;

    always_comb begin
        c  = state;
        fb = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
        next = c;
    end

endmodule

// File: rtl/crc_frame_ctrl.sv
// Frame-granular round-robin arbiter for two word streams; each frame is followed by its CRC-16 word.
// Optional macro CRC_MAXLEN_EN: frames are truncated after MAX_WORDS words and the remainder discarded.
module crc_frame_ctrl
    import crc_pkg::*;
#(
    parameter int MAX_WORDS = 256
) (
    input  logic             clk_in,
    input  logic             rst,
    crc_frame_ctrl_if.master bus
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] DATA = ST_DATA;
    localparam logic [1:0] CRC  = ST_CRC;
`ifdef CRC_MAXLEN_EN
    localparam logic [1:0] DROP = ST_DROP;
`endif

    if (MAX_WORDS < 1 || MAX_WORDS > 65536) begin : g_bad_max_words
        $error("crc_frame_ctrl: MAX_WORDS must be in 1..65536");
    end

    logic [1:0]  state_q;
    logic [1:0]  grant_q;
    logic        rr_q;
    logic [15:0] crc_q;
    logic [15:0] crc_nxt;
    logic        own_valid;
    logic        own_last;
    logic [15:0] own_data;
    logic        own_ready;
    logic        data_hs;
    logic        pick_req1;

`ifdef CRC_MAXLEN_EN
    logic [15:0] cnt_q;
    logic        drop_q;
    logic        err_q;
`endif

    always_comb begin
        own_valid = grant_q[1] ? bus.req1_valid : bus.req0_valid;
        own_last  = grant_q[1] ? bus.req1_last  : bus.req0_last;
        own_data  = grant_q[1] ? bus.req1_data  : bus.req0_data;
    end

    assign data_hs   = (state_q == DATA) && own_valid && bus.out_ready;
    // rr_q=1 favours req1; otherwise req0 wins whenever it is valid
    assign pick_req1 = rr_q ? bus.req1_valid : !bus.req0_valid;

    crc16_next u_crc16_next (
        .state (crc_q),
        .data  (own_data),
        .next  (crc_nxt)
    );

    always_comb begin
        bus.out_valid  = 1'b0;
        bus.out_data   = crc_q;
        bus.out_last   = 1'b0;
        bus.out_is_crc = 1'b0;
        own_ready      = 1'b0;
        case (state_q)
            DATA: begin
                bus.out_valid = own_valid;
                bus.out_data  = own_data;
                own_ready     = bus.out_ready;
            end
            CRC: begin
                bus.out_valid  = 1'b1;
                bus.out_last   = 1'b1;
                bus.out_is_crc = 1'b1;
            end
`ifdef CRC_MAXLEN_EN
            DROP: own_ready = 1'b1;
`endif
            default: ;
        endcase
        bus.req0_ready = grant_q[0] & own_ready;
        bus.req1_ready = grant_q[1] & own_ready;
    end

    assign bus.grant = grant_q;
`ifdef CRC_MAXLEN_EN
    assign bus.err_trunc = err_q;
`else
    assign bus.err_trunc = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            rr_q    <= 1'b0;
            crc_q   <= CRC_INIT;
`ifdef CRC_MAXLEN_EN
            cnt_q   <= 16'd0;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
`ifdef CRC_MAXLEN_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.req0_valid || bus.req1_valid) begin
                        grant_q <= pick_req1 ? 2'b10 : 2'b01;
                        rr_q    <= !pick_req1;
                        state_q <= DATA;
`ifdef CRC_MAXLEN_EN
                        cnt_q   <= 16'd0;
`endif
                    end
                end
                DATA: begin
                    if (data_hs) begin
                        crc_q <= crc_nxt;
`ifdef CRC_MAXLEN_EN
                        cnt_q <= cnt_q + 16'd1;
                        // over-long frame: close it with a CRC now, swallow the rest afterwards
                        if (!own_last && cnt_q == 16'(MAX_WORDS - 1)) begin
                            state_q <= CRC;
                            drop_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
`endif
                        if (own_last) begin
                            state_q <= CRC;
                        end
                    end
                end
                CRC: begin
                    if (bus.out_ready) begin
                        crc_q <= CRC_INIT;
`ifdef CRC_MAXLEN_EN
                        if (drop_q) begin
                            state_q <= DROP;
                            drop_q  <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            grant_q <= 2'b00;
                        end
`else
                        state_q <= IDLE;
                        grant_q <= 2'b00;
`endif
                    end
                end
`ifdef CRC_MAXLEN_EN
                DROP: begin
                    if (own_valid && own_last) begin
                        state_q <= IDLE;
                        grant_q <= 2'b00;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: doc/crc_frame_ctrl.md
CRC_FRAME_CTRL -- requirements
Module: crc_frame_ctrl

Interface
REQ-001 SHALL have parameter: MAX_WORDS, default 256, maximum data words per frame (used only with CRC_MAXLEN_EN).
REQ-002 SHALL have ports: clk_in  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: req0_valid/req1_valid  in  1 each  requester word valid.
REQ-005 SHALL have ports: req0_data/req1_data  in  16 each  requester data word.
REQ-006 SHALL have ports: req0_last/req1_last  in  1 each  final word of frame.
REQ-007 SHALL have ports: req0_ready/req1_ready  out  1 each  word accepted when valid&ready.
REQ-008 SHALL have ports: out_valid  out  1;  out_data  out  16;  out_last  out  1;  out_is_crc  out  1;  out_ready  in  1 (downstream stream).
REQ-009 SHALL have ports: grant  out  2  one-hot owner of current frame, 0 when idle.
REQ-010 SHALL have ports: err_trunc  out  1  one-cycle pulse on forced truncation.

Function
REQ-011 SHALL arbitrate at frame granularity; one owner from first accepted word until its CRC word handshakes.
REQ-012 SHALL use FSM IDLE -> DATA -> CRC -> IDLE, plus DROP when CRC_MAXLEN_EN defined.
REQ-013 IDLE: any req valid -> grant (round-robin, priority flips to other requester after each frame; req0 first after reset) -> DATA same cycle arbitration, grant registered.
REQ-014 DATA: out_valid=granted valid, out_data=granted data, out_last=0, out_is_crc=0, granted ready=out_ready; non-granted ready=0 in all states.
REQ-015 On each DATA handshake SHALL update CRC register with 16-bit parallel CRC-16, poly x^16+x^12+x^5+1 (0x1021), MSB-first, init 0x0000, no final XOR.
REQ-016 Handshake with granted last=1 -> CRC state next cycle; zero added latency for data words.
REQ-017 CRC: out_valid=1, out_data=CRC register, out_last=1, out_is_crc=1; on out_ready -> IDLE, CRC register cleared to 0x0000, grant=0.
REQ-018 SHALL hold out_data/out_valid stable while out_valid&!out_ready.
REQ-019 Single-word frame (first word last=1) SHALL yield one data word plus CRC word.
REQ-020 Request arriving on the cycle the CRC word handshakes SHALL be served no earlier than next cycle (IDLE visited for at least one cycle).

Reset
REQ-021 rst SHALL force: state IDLE, CRC 0x0000, grant 0, RR pointer to req0, out_valid 0, out_last 0, out_is_crc 0, ready outputs 0, err_trunc 0, word counter 0.
REQ-022 rst mid-frame SHALL abort frame silently; no CRC word emitted.

Configuration
REQ-023 Macro CRC_MAXLEN_EN defined: 16-bit word counter per frame; handshake of MAX_WORDS-th word without last SHALL go to CRC (CRC emitted normally), pulse err_trunc, then DROP.
REQ-024 DROP: owner ready=1, words discarded (not output, not CRC'd) until owner last handshake -> IDLE; grant held.
REQ-025 Macro undefined: no counter, no DROP state, err_trunc tied 0, frame length unbounded.

Structure
REQ-026 Shared package crc_pkg SHALL hold CRC_POLY (16'h1021), CRC_INIT (16'h0000), FSM state enum.
REQ-027 Combinational sub-module crc16_next (state[15:0], data[15:0] -> next[15:0]) SHALL implement the parallel update; controller registers the state.

Verification
REQ-028 req0 frame {0x0001, last} -> out: 0x0001 then CRC 0x1021 with out_last=1, out_is_crc=1.
REQ-029 req0 frame {0x0001, 0x0000 last} -> CRC word 0x3730; frame {0x0000 last} -> CRC 0x0000.
REQ-030 Both requesters valid continuously after reset -> grant order 01,10,01,10; no interleaved words.
REQ-031 out_ready toggled 1/0 random during frame and CRC word -> no loss/duplication, data stable while stalled.
REQ-032 rst asserted after 2 of 4 words -> no CRC word, next frame CRC starts from 0x0000 (single 0x0001 -> 0x1021).
REQ-033 CRC_MAXLEN_EN, MAX_WORDS=4, 6-word frame of 0x0000 -> 4 words out, CRC 0x0000, err_trunc one pulse, words 5-6 dropped, then IDLE.
